bus_cycle_controller: RTL
=========================

BUS_CYCLE_CONTROLLER -- requirements
Module: bus_cycle_controller

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of decoded slave channels (2..16).
REQ-002 SHALL have parameter WAIT_W, default 4, width of each per-slave wait-state field.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum WAIT cycles before bus error (must exceed 2^WAIT_W-1).
REQ-004 SHALL have port Clk  input  1  CPU clock; single clock domain, all logic on rising edge.
REQ-005 SHALL have port Reset_L  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port AS_L  input  1  CPU address strobe, active-low.
REQ-007 SHALL have port Select_H  input  NUM_SLAVES  decoded slave selects, active-high.
REQ-008 SHALL have port SlaveDtack_L  input  NUM_SLAVES  per-slave external acknowledge, active-low.
REQ-009 SHALL have port ExtDtackEn  input  NUM_SLAVES  per-slave mode: 1 = external Dtack, 0 = internal wait-state count.
REQ-010 SHALL have port WaitStates  input  NUM_SLAVES*WAIT_W  per-slave wait count; slave i at bits [i*WAIT_W +: WAIT_W].
REQ-011 SHALL have port Dtack_L  output  1  registered acknowledge to CPU, active-low.
REQ-012 SHALL have port Berr_L  output  1  registered bus error to CPU, active-low.
REQ-013 SHALL have port BusBusy_H  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port ActiveSlave  output  clog2(NUM_SLAVES)  latched slave index; valid only while BusBusy_H.
REQ-015 SHALL have port ErrCount  output  8  saturating count of timeouts since reset.

Function
REQ-016 SHALL implement states IDLE, WAIT, ACK, BERR.
REQ-017 IDLE: on edge E0 with AS_L sampled low SHALL go to WAIT, clear cycle counter, latch lowest-index asserted Select_H bit as ActiveSlave, latch its mode and wait count.
REQ-018 No Select_H bit at E0: SHALL enter WAIT with no slave able to acknowledge (timeout path only); ActiveSlave = 0.
REQ-019 Multiple Select_H bits at E0: lowest index wins, no error.
REQ-020 Select_H/WaitStates/ExtDtackEn changes after E0 SHALL be ignored for the current cycle; SlaveDtack_L of latched slave sampled live.
REQ-021 WAIT: counter increments each edge; width clog2(TIMEOUT_CYCLES+1); SHALL not wrap.
REQ-022 Internal mode: when counter == latched wait count, SHALL go to ACK and drive Dtack_L low from that edge; wait count W gives Dtack_L low after edge E0+W+1.
REQ-023 External mode: SlaveDtack_L[ActiveSlave] sampled low SHALL go to ACK with Dtack_L low at that same edge (one-edge register latency).
REQ-024 Counter reaching TIMEOUT_CYCLES without acknowledge SHALL go to BERR, drive Berr_L low, increment ErrCount (saturate at 255).
REQ-025 Acknowledge and timeout on the same edge: acknowledge wins, no error, ErrCount unchanged.
REQ-026 ACK/BERR: outputs held low until AS_L sampled high; on that edge SHALL return to IDLE with Dtack_L and Berr_L high.
REQ-027 AS_L sampled high in WAIT (aborted cycle): SHALL return to IDLE, no Dtack_L, no Berr_L, ErrCount unchanged.
REQ-028 Dtack_L and Berr_L SHALL never be low simultaneously.
REQ-029 Back-to-back cycles: a new AS_L low SHALL only be recognised from IDLE, so at least one IDLE edge with AS_L high separates cycles.

Reset
REQ-030 Reset_L sampled low SHALL force IDLE, Dtack_L=1, Berr_L=1, BusBusy_H=0, ActiveSlave=0, counter=0, ErrCount=0, overriding every other condition including mid-cycle.
REQ-031 After Reset_L release, an AS_L already low SHALL be treated as a new cycle start on the first edge with Reset_L high.

Verification
REQ-032 Internal wait: Select_H=0010, ExtDtackEn=0, slave1 WaitStates=3, AS_L low at E0 -> Dtack_L low after E4, high at edge after AS_L returns high; ErrCount=0.
REQ-033 External: slave2 ExtDtackEn=1, SlaveDtack_L[2] low at 6th WAIT edge -> Dtack_L low that edge, Berr_L stays high, ActiveSlave=2.
REQ-034 Timeout: Select_H=0000, AS_L held low -> Berr_L low after TIMEOUT_CYCLES WAIT edges, ErrCount 0->1; 256 repeats -> ErrCount=255.
REQ-035 Priority/abort: Select_H=1010 -> ActiveSlave=1; separately AS_L high at WAIT edge 2 of a W=5 cycle -> IDLE, no Dtack_L, no Berr_L.
REQ-036 Reset mid-cycle: Reset_L low during ACK with ErrCount=3 -> next edge Dtack_L=1, BusBusy_H=0, ErrCount=0.
REQ-037 Collision: external slave acknowledges on the exact timeout edge -> Dtack_L low, Berr_L high, ErrCount unchanged.

Source files
------------

// File: rtl/bus_cycle_controller.sv
// bus_cycle_controller
// Turns a CPU address strobe plus decoded slave selects into a registered
// Dtack_L or Berr_L. Each slave acknowledges either after a fixed number of
// wait states or through its own external acknowledge line. A cycle that is
// never acknowledged ends in a bus error after TIMEOUT_CYCLES wait edges.
module bus_cycle_controller #(
    parameter int NUM_SLAVES     = 4,
    parameter int WAIT_W         = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           Clk,
    input  logic                           Reset_L,
    input  logic                           AS_L,
    input  logic [NUM_SLAVES-1:0]          Select_H,
    input  logic [NUM_SLAVES-1:0]          SlaveDtack_L,
    input  logic [NUM_SLAVES-1:0]          ExtDtackEn,
    input  logic [NUM_SLAVES*WAIT_W-1:0]   WaitStates,
    output logic                           Dtack_L,
    output logic                           Berr_L,
    output logic                           BusBusy_H,
    output logic [$clog2(NUM_SLAVES)-1:0]  ActiveSlave,
    output logic [7:0]                     ErrCount
);

    localparam int SLV_W = $clog2(NUM_SLAVES);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // The count seen on the last WAIT edge before a timeout; the edge on
    // which the counter would reach TIMEOUT_CYCLES is the timeout edge.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        BERR = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_count;
    logic [SLV_W-1:0]   r_activeSlave;
    logic               r_slaveValid;
    logic               r_extMode;
    logic [WAIT_W-1:0]  r_waitCnt;
    logic               r_dtackL;
    logic               r_berrL;
    logic [7:0]         r_errCount;

    logic [SLV_W-1:0]   w_selIdx;
    logic               w_selAny;
    logic               w_selExt;
    logic [WAIT_W-1:0]  w_selWait;
    logic               w_intAck;
    logic               w_extAck;
    logic               w_ack;
    logic               w_timeout;

    // Priority-pick the lowest-index asserted select along with its mode and wait count.
    always_comb begin
        w_selIdx  = '0;
        w_selAny  = 1'b0;
        w_selExt  = 1'b0;
        w_selWait = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (Select_H[i]) begin
                w_selIdx  = SLV_W'(i);
                w_selAny  = 1'b1;
                w_selExt  = ExtDtackEn[i];
                w_selWait = WaitStates[i*WAIT_W +: WAIT_W];
            end
        end
    end

    // With no slave latched neither acknowledge source may fire, leaving only the timeout.
    assign w_intAck  = r_slaveValid && !r_extMode && (r_count == CNT_W'(r_waitCnt));
    assign w_extAck  = r_slaveValid && r_extMode && !SlaveDtack_L[r_activeSlave];
    assign w_ack     = w_intAck || w_extAck;
    assign w_timeout = (r_count == LAST_WAIT);

    // Next-state decode; an acknowledge beats a timeout on the same edge.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (!AS_L) begin
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (AS_L) begin
                    w_nextState = IDLE;
                end else if (w_ack) begin
                    w_nextState = ACK;
                end else if (w_timeout) begin
                    w_nextState = BERR;
                end
            end
            ACK, BERR: begin
                if (AS_L) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_L) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Cycle datapath: latch the slave at cycle start, count wait edges, register the strobes and tally timeouts.
    always_ff @(posedge Clk) begin
        if (!Reset_L) begin
            r_count       <= '0;
            r_activeSlave <= '0;
            r_slaveValid  <= 1'b0;
            r_extMode     <= 1'b0;
            r_waitCnt     <= '0;
            r_dtackL      <= 1'b1;
            r_berrL       <= 1'b1;
            r_errCount    <= 8'd0;
        end else begin
            r_dtackL <= (w_nextState != ACK);
            r_berrL  <= (w_nextState != BERR);

            if (r_state == IDLE && !AS_L) begin
                r_count       <= '0;
                r_activeSlave <= w_selIdx;
                r_slaveValid  <= w_selAny;
                r_extMode     <= w_selExt;
                r_waitCnt     <= w_selWait;
            end else if (r_state == WAIT) begin
                if (r_count != {CNT_W{1'b1}}) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else begin
                r_count <= '0;
            end

            if (r_state == WAIT && w_nextState == BERR && r_errCount != 8'hFF) begin
                r_errCount <= r_errCount + 8'd1;
            end
        end
    end

    assign Dtack_L     = r_dtackL;
    assign Berr_L      = r_berrL;
    assign BusBusy_H   = (r_state != IDLE);
    assign ActiveSlave = r_activeSlave;
    assign ErrCount    = r_errCount;

endmodule
